// File: rtl/fpnew_inorder_retire_if.sv
// Handshake bundle for the in-order retirement buffer.
// master: the FPU side that issues ops, feeds completions and consumes retired results.
// slave : the retirement buffer itself.
// Signals:
//   flush_i                          drop every in-flight entry on the next edge
//   issue_valid_i/ready_o/tag_i/id_o issue handshake; id_o is the slot granted to this issue
//   cpl_valid_i/ready_o/id_i/
//   cpl_result_i/status_i            one completion channel per opgroup
//   out_valid_o/ready_i/result_o/
//   status_o/tag_o                   head-of-buffer retirement port
//   busy_o                           at least one entry allocated
interface fpnew_inorder_retire_if #(
    parameter int unsigned Width   = 64,
    parameter int unsigned NumIn   = 5,
    parameter int unsigned Depth   = 8,
    parameter type         TagType = logic
);
    localparam int unsigned IdWidth = $clog2(Depth);

    logic                              flush_i;
    logic                              issue_valid_i;
    logic                              issue_ready_o;
    TagType                            issue_tag_i;
    logic [IdWidth-1:0]                issue_id_o;
    logic [NumIn-1:0]                  cpl_valid_i;
    logic [NumIn-1:0]                  cpl_ready_o;
    logic [NumIn-1:0][IdWidth-1:0]     cpl_id_i;
    logic [NumIn-1:0][Width-1:0]       cpl_result_i;
    logic [NumIn-1:0][4:0]             cpl_status_i;  // {NV, DZ, OF, UF, NX}
    logic                              out_valid_o;
    logic                              out_ready_i;
    logic [Width-1:0]                  result_o;
    logic [4:0]                        status_o;
    TagType                            tag_o;
    logic                              busy_o;

    modport master (
        output flush_i, issue_valid_i, issue_tag_i, cpl_valid_i, cpl_id_i, cpl_result_i,
               cpl_status_i, out_ready_i,
        input  issue_ready_o, issue_id_o, cpl_ready_o, out_valid_o, result_o, status_o, tag_o,
               busy_o
    );

    modport slave (
        input  flush_i, issue_valid_i, issue_tag_i, cpl_valid_i, cpl_id_i, cpl_result_i,
               cpl_status_i, out_ready_i,
        output issue_ready_o, issue_id_o, cpl_ready_o, out_valid_o, result_o, status_o, tag_o,
               busy_o
    );
endinterface

// File: rtl/fpnew_inorder_retire.sv
// In-order result retirement buffer (reorder buffer) for the FPU top level.
// Ops are issued into tail slots; opgroups complete them out of order by slot ID; the head
// slot retires through a valid/ready port, so results leave strictly in issue order.
// Ports:
//   clk_i  clock, all state on the rising edge
//   rst_i  asynchronous active-high reset
//   bus    fpnew_inorder_retire_if.slave (issue, completion, retirement, flush, busy)
module fpnew_inorder_retire #(
    parameter int unsigned Width   = 64,
    parameter int unsigned NumIn   = 5,
    parameter int unsigned Depth   = 8,
    parameter type         TagType = logic
) (
    input logic                    clk_i,
    input logic                    rst_i,
    fpnew_inorder_retire_if.slave  bus
);
    localparam int unsigned IdWidth = $clog2(Depth);

    typedef logic [IdWidth:0] ptr_t;  // MSB is the wrap bit

    ptr_t               head_q, head_d, tail_q, tail_d;
    logic [Depth-1:0]   done_q, done_d;
    TagType             tag_q    [Depth];
    logic [Width-1:0]   result_q [Depth];
    logic [4:0]         status_q [Depth];

    logic [IdWidth-1:0] head_idx, tail_idx;
    ptr_t               count;
    logic               empty, full;
    logic               issue_fire, retire_fire;
    logic [Depth-1:0]   alloc;
    logic [Depth-1:0]   cpl_we;
    logic [Width-1:0]   cpl_res_sel [Depth];
    logic [4:0]         cpl_st_sel  [Depth];

    assign head_idx = head_q[IdWidth-1:0];
    assign tail_idx = tail_q[IdWidth-1:0];
    assign count    = tail_q - head_q;
    assign empty    = (head_q == tail_q);
    assign full     = (head_idx == tail_idx) && (head_q[IdWidth] != tail_q[IdWidth]);

    assign bus.issue_ready_o = !full && !bus.flush_i;
    assign bus.issue_id_o    = tail_idx;
    assign bus.cpl_ready_o   = '1;
    assign bus.out_valid_o   = !empty && done_q[head_idx];
    assign bus.result_o      = result_q[head_idx];
    assign bus.status_o      = status_q[head_idx];
    assign bus.tag_o         = tag_q[head_idx];
    assign bus.busy_o        = !empty;

    assign issue_fire  = bus.issue_valid_i && bus.issue_ready_o;
    assign retire_fire = bus.out_valid_o && bus.out_ready_i && !bus.flush_i;

    // Per-slot completion select. Channels are scanned high to low so the lowest index wins
    // on a (illegal) duplicate ID. A slot is allocated when its distance from head is below
    // the occupancy; completions to anything else are dropped.
    always_comb begin
        for (int i = 0; i < Depth; i++) begin
            logic [IdWidth-1:0] offset;
            logic               hit;
            offset         = IdWidth'(i) - head_idx;
            alloc[i]       = ({1'b0, offset} < count);
            hit            = 1'b0;
            cpl_res_sel[i] = '0;
            cpl_st_sel[i]  = '0;
            for (int k = NumIn - 1; k >= 0; k--) begin
                if (bus.cpl_valid_i[k] && (bus.cpl_id_i[k] == IdWidth'(i))) begin
                    hit            = 1'b1;
                    cpl_res_sel[i] = bus.cpl_result_i[k];
                    cpl_st_sel[i]  = bus.cpl_status_i[k];
                end
            end
            cpl_we[i] = hit && alloc[i] && !bus.flush_i;
        end
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        done_d = done_q;
        if (bus.flush_i) begin
            head_d = '0;
            tail_d = '0;
            done_d = '0;
        end else begin
            if (issue_fire) begin
                done_d[tail_idx] = 1'b0;
                tail_d           = tail_q + ptr_t'(1);
            end
            done_d = done_d | cpl_we;
            if (retire_fire) begin
                done_d[head_idx] = 1'b0;
                head_d           = head_q + ptr_t'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            done_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                tag_q[i]    <= '0;
                result_q[i] <= '0;
                status_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            done_q <= done_d;
            for (int i = 0; i < Depth; i++) begin
                if (issue_fire && (tail_idx == IdWidth'(i))) begin
                    tag_q[i] <= bus.issue_tag_i;
                end
                if (cpl_we[i]) begin
                    result_q[i] <= cpl_res_sel[i];
                    status_q[i] <= cpl_st_sel[i];
                end
            end
        end
    end

`ifndef SYNTHESIS
    // Completions must target allocated slots, and no two channels may share an ID.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !bus.flush_i) begin
            for (int k = 0; k < NumIn; k++) begin
                if (bus.cpl_valid_i[k]) begin
                    assert (alloc[bus.cpl_id_i[k]]);
                end
                for (int j = 0; j < k; j++) begin
                    assert (!(bus.cpl_valid_i[j] && bus.cpl_valid_i[k] &&
                              (bus.cpl_id_i[j] == bus.cpl_id_i[k])));
                end
            end
        end
    end
`endif
endmodule
